bsg_fpu_f2i_accum: RTL and testbench



---
 rtl/bsg_fpu_f2i_accum_pkg.sv | 29 ++
 rtl/bsg_fpu_sat_add.sv | 54 +++++
 rtl/bsg_fpu_f2i_accum.sv | 157 +++++++++++++++
 tb/tb_bsg_fpu_f2i_accum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fpu_f2i_accum_pkg.sv
// Shared definitions for the float-to-int block accumulator.
//   state_e          : controller states (IDLE, ACCUM, DONE)
//   sat_*            : saturation limits for a given accumulator width,
//                      returned as 64-bit bit patterns whose low w bits
//                      are the limit in w-bit representation.
package bsg_fpu_f2i_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest two's complement value: 0111...1
  function automatic logic [63:0] sat_max_signed(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value: 1000...0
  function automatic logic [63:0] sat_min_signed(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Largest unsigned value: 1111...1 (w = 64 wraps the shift to 0, still all ones)
  function automatic logic [63:0] sat_max_unsigned(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/bsg_fpu_sat_add.sv
// Combinational saturating adder for the block accumulator.
// Ports:
//   acc_i    : current accumulator value
//   sample_i : sample already extended to the accumulator width
//   signed_i : 1 = two's complement clamp, 0 = unsigned clamp
//   sum_o    : clamped sum
//   sat_o    : 1 when the sum was clamped
module bsg_fpu_sat_add
  import bsg_fpu_f2i_accum_pkg::*;
#(
  parameter int acc_width_p = 32
) (
  input  logic [acc_width_p-1:0] acc_i,
  input  logic [acc_width_p-1:0] sample_i,
  input  logic                   signed_i,
  output logic [acc_width_p-1:0] sum_o,
  output logic                   sat_o
);

  localparam logic [63:0] max_s_full_lp = sat_max_signed(acc_width_p);
  localparam logic [63:0] min_s_full_lp = sat_min_signed(acc_width_p);
  localparam logic [63:0] max_u_full_lp = sat_max_unsigned(acc_width_p);

  localparam logic [acc_width_p-1:0] max_s_lp = max_s_full_lp[acc_width_p-1:0];
  localparam logic [acc_width_p-1:0] min_s_lp = min_s_full_lp[acc_width_p-1:0];
  localparam logic [acc_width_p-1:0] max_u_lp = max_u_full_lp[acc_width_p-1:0];

  logic [acc_width_p:0] sum_wide;

  always_comb begin
    sum_wide = '0;
    sum_o    = '0;
    sat_o    = 1'b0;
    if (signed_i) begin
      sum_wide = {acc_i[acc_width_p-1], acc_i} + {sample_i[acc_width_p-1], sample_i};
      // Top two bits disagree only on signed overflow; the top bit gives the true sign.
      if (sum_wide[acc_width_p] != sum_wide[acc_width_p-1]) begin
        sat_o = 1'b1;
        sum_o = sum_wide[acc_width_p] ? min_s_lp : max_s_lp;
      end else begin
        sum_o = sum_wide[acc_width_p-1:0];
      end
    end else begin
      sum_wide = {1'b0, acc_i} + {1'b0, sample_i};
      if (sum_wide[acc_width_p]) begin
        sat_o = 1'b1;
        sum_o = max_u_lp;
      end else begin
        sum_o = sum_wide[acc_width_p-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_fpu_f2i_accum.sv
// Block accumulator behind the half-precision float-to-int converter.
// Sums len_i converted samples (len_i = 0 means 1) into a saturating
// accumulator with sticky invalid/overflow flags, then holds the result
// on a valid/yumi handshake.
// Ports:
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   v_i / ready_o        : sample handshake
//   data_i, invalid_i    : converted sample and its invalid flag
//   signed_i, len_i      : block format and length, sampled at block start
//   clear_i              : synchronous abort, beats v_i and yumi_i
//   v_o / yumi_i         : result handshake
//   sum_o, count_o, invalid_o, overflow_o : block result
// Build option:
//   BSG_FPU_F2I_ACCUM_SKIP_INVALID_EN : invalid samples are counted and
//   flagged but add 0 to the sum.
module bsg_fpu_f2i_accum
  import bsg_fpu_f2i_accum_pkg::*;
#(
  parameter int width_p       = 16,
  parameter int acc_width_p   = 32,
  parameter int count_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       data_i,
  input  logic                     invalid_i,
  input  logic                     signed_i,
  input  logic [count_width_p-1:0] len_i,
  input  logic                     clear_i,
  output logic                     v_o,
  output logic [acc_width_p-1:0]   sum_o,
  output logic [count_width_p-1:0] count_o,
  output logic                     invalid_o,
  output logic                     overflow_o,
  input  logic                     yumi_i
);

  localparam logic [count_width_p-1:0] one_lp = {{(count_width_p-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [acc_width_p-1:0]   sum_q, sum_d;
  logic [count_width_p-1:0] count_q, count_d;
  logic [count_width_p-1:0] len_q, len_d;
  logic                     signed_q, signed_d;
  logic                     invalid_q, invalid_d;
  logic                     overflow_q, overflow_d;

  logic [count_width_p-1:0] len_start;
  logic [count_width_p-1:0] count_inc;
  logic                     signed_eff;
  logic [acc_width_p-1:0]   ext_sample;
  logic [acc_width_p-1:0]   add_sample;
  logic [acc_width_p-1:0]   sat_sum;
  logic                     sat;

  assign len_start  = (len_i == '0) ? one_lp : len_i;
  assign count_inc  = count_q + one_lp;
  // The first sample is taken in IDLE, before signed_i has been latched.
  assign signed_eff = (state_q == IDLE) ? signed_i : signed_q;
  assign ext_sample = signed_eff
                    ? {{(acc_width_p-width_p){data_i[width_p-1]}}, data_i}
                    : {{(acc_width_p-width_p){1'b0}}, data_i};

`ifdef BSG_FPU_F2I_ACCUM_SKIP_INVALID_EN
  assign add_sample = invalid_i ? '0 : ext_sample;
`else
  assign add_sample = ext_sample;
`endif

  bsg_fpu_sat_add #(
    .acc_width_p(acc_width_p)
  ) sat_add (
    .acc_i    (sum_q),
    .sample_i (add_sample),
    .signed_i (signed_eff),
    .sum_o    (sat_sum),
    .sat_o    (sat)
  );

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    len_d      = len_q;
    signed_d   = signed_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      state_d    = IDLE;
      sum_d      = '0;
      count_d    = '0;
      len_d      = '0;
      signed_d   = 1'b0;
      invalid_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (v_i) begin
          signed_d   = signed_i;
          len_d      = len_start;
          sum_d      = sat_sum;
          count_d    = one_lp;
          invalid_d  = invalid_i;
          overflow_d = sat;
          state_d    = (len_start == one_lp) ? DONE : ACCUM;
        end
        ACCUM: if (v_i) begin
          sum_d      = sat_sum;
          count_d    = count_inc;
          invalid_d  = invalid_q | invalid_i;
          overflow_d = overflow_q | sat;
          if (count_inc == len_q) state_d = DONE;
        end
        DONE: if (yumi_i) begin
          state_d    = IDLE;
          sum_d      = '0;
          count_d    = '0;
          len_d      = '0;
          signed_d   = 1'b0;
          invalid_d  = 1'b0;
          overflow_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      signed_q   <= 1'b0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      len_q      <= len_d;
      signed_q   <= signed_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready_o    = (state_q != DONE);
  assign v_o        = (state_q == DONE);
  assign sum_o      = sum_q;
  assign count_o    = count_q;
  assign invalid_o  = invalid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bsg_fpu_f2i_accum.sv
// Bench for bsg_fpu_f2i_accum: a 32-bit and a 17-bit accumulator share
// one stimulus stream. Hand-computed vector table, randomized blocks
// against an integer-arithmetic model, and clear/reset sequences.
module tb_bsg_fpu_f2i_accum;

`ifdef BSG_FPU_F2I_ACCUM_SKIP_INVALID_EN
  localparam bit skip_lp = 1'b1;
`else
  localparam bit skip_lp = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        invalid_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [7:0]  len_i = '0;
  logic        clear_i = 1'b0;
  logic        yumi_i = 1'b0;

  logic        ready_a, v_a, inv_a, ovf_a;
  logic [31:0] sum_a;
  logic [7:0]  count_a;
  logic        ready_b, v_b, inv_b, ovf_b;
  logic [16:0] sum_b;
  logic [7:0]  count_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] blk_d   [16];
  logic        blk_inv [16];

  always #5 clk_i = ~clk_i;

  bsg_fpu_f2i_accum #(.width_p(16), .acc_width_p(32), .count_width_p(8)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_a),
    .data_i(data_i), .invalid_i(invalid_i), .signed_i(signed_i), .len_i(len_i),
    .clear_i(clear_i), .v_o(v_a), .sum_o(sum_a), .count_o(count_a),
    .invalid_o(inv_a), .overflow_o(ovf_a), .yumi_i(yumi_i));

  bsg_fpu_f2i_accum #(.width_p(16), .acc_width_p(17), .count_width_p(8)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_b),
    .data_i(data_i), .invalid_i(invalid_i), .signed_i(signed_i), .len_i(len_i),
    .clear_i(clear_i), .v_o(v_b), .sum_o(sum_b), .count_o(count_b),
    .invalid_o(inv_b), .overflow_o(ovf_b), .yumi_i(yumi_i));

  always @(posedge clk_i) begin
    if (!reset_i && yumi_i) begin
      assert (v_a && v_b)
      else begin
        errors++;
        $display("FAIL yumi_legal: yumi_i high with v_o a=%0b b=%0b, need 1", v_a, v_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: signed integer sum with clamping after every add.
  function automatic void model(input int aw, input bit sgn, input int n,
                                output longint s, output bit ovf);
    longint hi, lo, x;
    s = 0;
    ovf = 1'b0;
    hi = sgn ? (longint'(1) <<< (aw - 1)) - 1 : (longint'(1) <<< aw) - 1;
    lo = sgn ? -(longint'(1) <<< (aw - 1)) : 0;
    for (int i = 0; i < n; i++) begin
      x = sgn ? longint'($signed(blk_d[i])) : longint'(blk_d[i]);
      if (skip_lp && blk_inv[i]) x = 0;
      s = s + x;
      if (s > hi) begin s = hi; ovf = 1'b1; end
      else if (s < lo) begin s = lo; ovf = 1'b1; end
    end
  endfunction

  // Feeds n samples; signed_i/len_i are scrambled after the first sample
  // since the block must ignore them once started.
  task automatic apply_block(input bit sgn, input logic [7:0] len, input int n);
    for (int i = 0; i < n; i++) begin
      v_i       = 1'b1;
      data_i    = blk_d[i];
      invalid_i = blk_inv[i];
      signed_i  = (i == 0) ? sgn : ~sgn;
      len_i     = (i == 0) ? len : 8'd1;
      @(posedge clk_i); #1;
    end
    v_i       = 1'b0;
    invalid_i = 1'b0;
    data_i    = 16'(($urandom));
  endtask

  task automatic check_done(input string name, input logic [31:0] e32, input bit o32,
                            input logic [16:0] e17, input bit o17,
                            input logic [7:0] cnt, input bit einv);
    chk({name, ".v_o"},      64'(v_a && v_b), 64'd1);
    chk({name, ".ready"},    64'(ready_a),   64'd0);
    chk({name, ".sum32"},    64'(sum_a),     64'(e32));
    chk({name, ".ovf32"},    64'(ovf_a),     64'(o32));
    chk({name, ".sum17"},    64'(sum_b),     64'(e17));
    chk({name, ".ovf17"},    64'(ovf_b),     64'(o17));
    chk({name, ".count"},    64'(count_a),   64'(cnt));
    chk({name, ".invalid"},  64'(inv_a),     64'(einv));
    // Result must hold, and a sample offered in DONE must be ignored.
    v_i = 1'b1; data_i = 16'h1234;
    @(posedge clk_i); #1;
    chk({name, ".hold_sum"},   64'(sum_a),   64'(e32));
    chk({name, ".hold_count"}, 64'(count_a), 64'(cnt));
    // Sample offered in the yumi cycle is not accepted either.
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0; v_i = 1'b0;
    chk({name, ".post_v"},     64'(v_a),     64'd0);
    chk({name, ".post_ready"}, 64'(ready_a), 64'd1);
    chk({name, ".post_count"}, 64'(count_a), 64'd0);
    chk({name, ".post_sum"},   64'(sum_a),   64'd0);
    chk({name, ".post_flags"}, 64'({inv_a, ovf_a}), 64'd0);
  endtask

  typedef struct {
    bit              sgn;
    logic [7:0]      len;
    int              n;
    logic [3:0][15:0] d;
    logic [3:0]      inv;
    logic [31:0]     e32;
    bit              o32;
    logic [16:0]     e17;
    bit              o17;
    bit              einv;
  } vec_t;

  vec_t vec [9];

  initial begin
    longint s32, s17;
    bit o32, o17, einv, sgn;
    int n;
    logic [7:0] len;

    vec[0] = '{1'b1, 8'd3, 3, {16'd0, 16'd100, 16'hFFFE, 16'd5}, 4'b0000,
               32'd103, 1'b0, 17'd103, 1'b0, 1'b0};
    vec[1] = '{1'b0, 8'd0, 1, {16'd0, 16'd0, 16'd0, 16'hFFFF}, 4'b0000,
               32'd65535, 1'b0, 17'd65535, 1'b0, 1'b0};
    vec[2] = '{1'b1, 8'd4, 4, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b0000,
               32'd131068, 1'b0, 17'd65535, 1'b1, 1'b0};
    vec[3] = '{1'b1, 8'd2, 2, {16'd0, 16'd0, 16'd3, 16'd7}, 4'b0001,
               skip_lp ? 32'd3 : 32'd10, 1'b0, skip_lp ? 17'd3 : 17'd10, 1'b0, 1'b1};
    vec[4] = '{1'b0, 8'd2, 2, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, 4'b0000,
               32'd131070, 1'b0, 17'd131070, 1'b0, 1'b0};
    vec[5] = '{1'b1, 8'd4, 4, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 4'b0000,
               32'hFFFE0000, 1'b0, 17'h10000, 1'b1, 1'b0};
    vec[6] = '{1'b0, 8'd3, 3, {16'd0, 16'd3, 16'd2, 16'd1}, 4'b0010,
               skip_lp ? 32'd4 : 32'd6, 1'b0, skip_lp ? 17'd4 : 17'd6, 1'b0, 1'b1};
    vec[7] = '{1'b1, 8'd1, 1, {16'd0, 16'd0, 16'd0, 16'hFFFF}, 4'b0000,
               32'hFFFFFFFF, 1'b0, 17'h1FFFF, 1'b0, 1'b0};
    vec[8] = '{1'b0, 8'd3, 3, {16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 4'b0000,
               32'd196605, 1'b0, 17'd131071, 1'b1, 1'b0};

    // Reset state, observed before any clock edge.
    #1;
    chk("reset.ready", 64'(ready_a), 64'd1);
    chk("reset.v_o",   64'(v_a),     64'd0);
    chk("reset.sum",   64'(sum_a),   64'd0);
    chk("reset.count", 64'(count_a), 64'd0);
    chk("reset.flags", 64'({inv_a, ovf_a}), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 4; j++) begin
        blk_d[j]   = vec[i].d[j];
        blk_inv[j] = vec[i].inv[j];
      end
      apply_block(vec[i].sgn, vec[i].len, vec[i].n);
      check_done($sformatf("vec%0d", i), vec[i].e32, vec[i].o32, vec[i].e17, vec[i].o17,
                 8'(vec[i].n), vec[i].einv);
    end

    for (int k = 0; k < 30; k++) begin
      sgn  = 1'($urandom_range(0, 1));
      len  = 8'($urandom_range(0, 6));
      n    = (len == 0) ? 1 : int'(len);
      einv = 1'b0;
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 4))
          0: blk_d[j] = 16'h7FFF;
          1: blk_d[j] = 16'h8000;
          2: blk_d[j] = 16'hFFFF;
          default: blk_d[j] = 16'($urandom);
        endcase
        blk_inv[j] = ($urandom_range(0, 3) == 0);
        einv = einv | blk_inv[j];
      end
      model(32, sgn, n, s32, o32);
      model(17, sgn, n, s17, o17);
      apply_block(sgn, len, n);
      check_done($sformatf("rand%0d", k), s32[31:0], o32, s17[16:0], o17, 8'(n), einv);
    end

    // Abort mid-block with a sample alongside clear_i.
    blk_d[0] = 16'd11; blk_inv[0] = 1'b0;
    blk_d[1] = 16'd22; blk_inv[1] = 1'b0;
    apply_block(1'b1, 8'd4, 2);
    chk("clear.pre_v",     64'(v_a),     64'd0);
    chk("clear.pre_count", 64'(count_a), 64'd2);
    clear_i = 1'b1; v_i = 1'b1; data_i = 16'd50;
    @(posedge clk_i); #1;
    clear_i = 1'b0; v_i = 1'b0;
    chk("clear.v_o",   64'(v_a),     64'd0);
    chk("clear.ready", 64'(ready_a), 64'd1);
    chk("clear.count", 64'(count_a), 64'd0);
    chk("clear.sum",   64'(sum_a),   64'd0);
    blk_d[0] = 16'd9;
    apply_block(1'b1, 8'd1, 1);
    check_done("clear.next", 32'd9, 1'b0, 17'd9, 1'b0, 8'd1, 1'b0);

    // Asynchronous reset in the middle of ACCUM.
    apply_block(1'b1, 8'd4, 2);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_accum.sum",   64'(sum_a),   64'd0);
    chk("rst_accum.count", 64'(count_a), 64'd0);
    chk("rst_accum.ready", 64'(ready_a), 64'd1);
    chk("rst_accum.v_o",   64'(v_a),     64'd0);
    @(negedge clk_i); reset_i = 1'b0;
    @(posedge clk_i); #1;
    blk_d[0] = 16'd4; blk_d[1] = 16'd6; blk_inv[0] = 1'b0; blk_inv[1] = 1'b0;
    apply_block(1'b1, 8'd2, 2);
    check_done("rst_accum.next", 32'd10, 1'b0, 17'd10, 1'b0, 8'd2, 1'b0);

    // Asynchronous reset while the result is waiting in DONE.
    blk_d[0] = 16'd9;
    apply_block(1'b0, 8'd1, 1);
    chk("rst_done.pre_v", 64'(v_a), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_done.v_o",   64'(v_a),     64'd0);
    chk("rst_done.sum",   64'(sum_a),   64'd0);
    chk("rst_done.count", 64'(count_a), 64'd0);
    chk("rst_done.ready", 64'(ready_a), 64'd1);
    @(negedge clk_i); reset_i = 1'b0;
    @(posedge clk_i); #1;
    blk_d[0] = 16'd3;
    apply_block(1'b0, 8'd1, 1);
    check_done("rst_done.next", 32'd3, 1'b0, 17'd3, 1'b0, 8'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
